// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: fixed-latency word fetch with misalign/range error flags and a byte-enabled load port.
// Optional fetch/error performance counters are built when INSTR_MEM_PERF_EN is defined.
module instr_mem_resp #(
    parameter int unsigned MEM_DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_be_i
`ifdef INSTR_MEM_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH_WORDS);

    logic [DATA_W-1:0] w_fetch_off;
    logic              w_fetch_inrange;
    logic              w_fetch_err;
    logic [IDX_W-1:0]  w_fetch_idx;

    logic [DATA_W-1:0] w_wr_off;
    logic              w_wr_inrange;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_unused_wr_lsb;

    logic [3:0][7:0]   r_mem [MEM_DEPTH_WORDS];

    logic [DATA_W-1:0] r_rdword_p1;
    logic              r_vld_p1;
    logic              r_err_p1;
    logic              r_zero_p1;
    logic [DATA_W-1:0] w_data_p1;

    logic              w_rvalid;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    // BASE_ADDR is word aligned, so the offset's low bits equal the address's low bits.
    assign w_fetch_off     = instr_addr_i - BASE_ADDR;
    assign w_fetch_inrange = (w_fetch_off[DATA_W-1:IDX_W+2] == '0);
    assign w_fetch_err     = (w_fetch_off[1:0] != 2'b00) || !w_fetch_inrange;
    assign w_fetch_idx     = w_fetch_off[IDX_W+1:2];

    assign w_wr_off        = wr_addr_i - BASE_ADDR;
    assign w_wr_inrange    = (w_wr_off[DATA_W-1:IDX_W+2] == '0);
    assign w_wr_idx        = w_wr_off[IDX_W+1:2];
    assign w_unused_wr_lsb = ^w_wr_off[1:0];

    always_ff @(posedge clk_i) begin
        if (wr_en_i && w_wr_inrange) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    r_mem[w_wr_idx][b] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // ---- stage p1: array read (sees pre-write contents on a same-edge write) ----
    always_ff @(posedge clk_i) begin
        if (fetch_en_i && !w_fetch_err) begin
            r_rdword_p1 <= r_mem[w_fetch_idx];
        end
    end

    // r_zero_p1 marks that the most recent response (or reset) requires a zero data word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1  <= 1'b0;
            r_err_p1  <= 1'b0;
            r_zero_p1 <= 1'b1;
        end else begin
            r_vld_p1 <= fetch_en_i;
            r_err_p1 <= fetch_en_i && w_fetch_err;
            if (fetch_en_i) begin
                r_zero_p1 <= w_fetch_err;
            end
        end
    end

    assign w_data_p1 = r_zero_p1 ? '0 : r_rdword_p1;

    generate
        if (LATENCY <= 1) begin : g_lat1
            assign w_rvalid = r_vld_p1;
            assign w_err    = r_vld_p1 && r_err_p1;
            assign w_rdata  = w_data_p1;
        end else begin : g_dly
            logic              r_vld_dly  [LATENCY-1];
            logic              r_err_dly  [LATENCY-1];
            logic [DATA_W-1:0] r_data_dly [LATENCY-1];

            // ---- stages p2..pN: pure delay, each data stage holds its last valid word ----
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < int'(LATENCY) - 1; k++) begin
                        r_vld_dly[k]  <= 1'b0;
                        r_err_dly[k]  <= 1'b0;
                        r_data_dly[k] <= '0;
                    end
                end else begin
                    r_vld_dly[0] <= r_vld_p1;
                    r_err_dly[0] <= r_err_p1;
                    if (r_vld_p1) begin
                        r_data_dly[0] <= w_data_p1;
                    end
                    for (int k = 1; k < int'(LATENCY) - 1; k++) begin
                        r_vld_dly[k] <= r_vld_dly[k-1];
                        r_err_dly[k] <= r_err_dly[k-1];
                        if (r_vld_dly[k-1]) begin
                            r_data_dly[k] <= r_data_dly[k-1];
                        end
                    end
                end
            end

            assign w_rvalid = r_vld_dly[LATENCY-2];
            assign w_err    = r_vld_dly[LATENCY-2] && r_err_dly[LATENCY-2];
            assign w_rdata  = r_data_dly[LATENCY-2];
        end
    endgenerate

    assign instr_rvalid_o = w_rvalid;
    assign instr_err_o    = w_err;
    assign instr_rdata_o  = w_rdata;

`ifdef INSTR_MEM_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_err_cnt;

    // Fetches count at request time; errors count when the error response is delivered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (fetch_en_i) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign err_cnt_o   = r_err_cnt;
`else
    // Counters are not built; the response path above is unchanged.
`endif

endmodule

// File: tb/tb_instr_mem_resp.sv
// Directed bench for instr_mem_resp: LATENCY=1 default map, a 16-word map at 0x1000, and a LATENCY=3 instance.
module tb_instr_mem_resp;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [31:0] l1_rdata, rng_rdata, l3_rdata;
    logic        l1_vld, rng_vld, l3_vld;
    logic        l1_err, rng_err, l3_err;
`ifdef INSTR_MEM_PERF_EN
    logic [31:0] l1_fcnt, rng_fcnt, l3_fcnt;
    logic [15:0] l1_ecnt, rng_ecnt, l3_ecnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

    instr_mem_resp u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .instr_addr_i(addr),
        .instr_rdata_o(l1_rdata), .instr_rvalid_o(l1_vld), .instr_err_o(l1_err),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be)
`ifdef INSTR_MEM_PERF_EN
        , .fetch_cnt_o(l1_fcnt), .err_cnt_o(l1_ecnt)
`endif
    );

    instr_mem_resp #(.MEM_DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(1)) u_dut_rng (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .instr_addr_i(addr),
        .instr_rdata_o(rng_rdata), .instr_rvalid_o(rng_vld), .instr_err_o(rng_err),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be)
`ifdef INSTR_MEM_PERF_EN
        , .fetch_cnt_o(rng_fcnt), .err_cnt_o(rng_ecnt)
`endif
    );

    instr_mem_resp #(.MEM_DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0000), .LATENCY(3)) u_dut_l3 (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .instr_addr_i(addr),
        .instr_rdata_o(l3_rdata), .instr_rvalid_o(l3_vld), .instr_err_o(l3_err),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be)
`ifdef INSTR_MEM_PERF_EN
        , .fetch_cnt_o(l3_fcnt), .err_cnt_o(l3_ecnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        cyc(); cyc();
        chk("rst_l1_vld", 32'(l1_vld), 32'd0);
        chk("rst_l1_err", 32'(l1_err), 32'd0);
        chk("rst_l1_rdata", l1_rdata, 32'h0);
        chk("rst_l3_vld", 32'(l3_vld), 32'd0);
        chk("rst_l3_rdata", l3_rdata, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Program load and back-to-back fetch
        for (int i = 0; i < 4; i++) wr(32'(4 * i), prog[i], 4'hF);
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(4 * i);
            cyc();
            chk("b2b_vld", 32'(l1_vld), 32'd1);
            chk("b2b_rdata", l1_rdata, prog[i]);
            chk("b2b_err", 32'(l1_err), 32'd0);
        end
        fetch_en = 1'b0;
        cyc();
        chk("idle_vld", 32'(l1_vld), 32'd0);
        chk("idle_hold", l1_rdata, prog[3]);
        chk("idle_err", 32'(l1_err), 32'd0);

        // Misaligned fetch then aligned
        fetch_en = 1'b1; addr = 32'h0000_0002;
        cyc();
        chk("mis_vld", 32'(l1_vld), 32'd1);
        chk("mis_err", 32'(l1_err), 32'd1);
        chk("mis_rdata", l1_rdata, 32'h0);
        addr = 32'h0;
        cyc();
        chk("after_mis_rdata", l1_rdata, 32'h00000013);
        chk("after_mis_err", 32'(l1_err), 32'd0);
        fetch_en = 1'b0;
        cyc();
        chk("err_idle_hold", l1_rdata, 32'h00000013);

        // Same-cycle read/write of word 1, then partial byte write
        fetch_en = 1'b1; addr = 32'h4;
        wr(32'h4, 32'hDEADBEEF, 4'hF);
        chk("rbw_old", l1_rdata, 32'h00100093);
        cyc();
        chk("rbw_new", l1_rdata, 32'hDEADBEEF);
        fetch_en = 1'b0;
        wr(32'h4, 32'h000000AA, 4'b0001);
        fetch_en = 1'b1;
        cyc();
        chk("be_byte0", l1_rdata, 32'hDEADBEAA);
        fetch_en = 1'b0;

        // Range check on the 16-word map at 0x1000
        wr(32'h0000_103C, 32'hCAFE0001, 4'hF);
        wr(32'h0000_1000, 32'h11111111, 4'hF);
        wr(32'h0000_1040, 32'h22222222, 4'hF);
        fetch_en = 1'b1; addr = 32'h0000_103C;
        cyc();
        chk("rng_top_vld", 32'(rng_vld), 32'd1);
        chk("rng_top_rdata", rng_rdata, 32'hCAFE0001);
        chk("rng_top_err", 32'(rng_err), 32'd0);
        addr = 32'h0000_1040;
        cyc();
        chk("rng_over_err", 32'(rng_err), 32'd1);
        chk("rng_over_rdata", rng_rdata, 32'h0);
        addr = 32'h0000_0FFC;
        cyc();
        chk("rng_under_err", 32'(rng_err), 32'd1);
        chk("rng_under_rdata", rng_rdata, 32'h0);
        addr = 32'h0000_1000;
        cyc();
        chk("rng_oor_wr_dropped", rng_rdata, 32'h11111111);
        chk("rng_base_err", 32'(rng_err), 32'd0);
        fetch_en = 1'b0;
        cyc(); cyc(); cyc(); cyc();

        // LATENCY=3: requests at edges 1,2,4
        fetch_en = 1'b1; addr = 32'h0;
        cyc();
        chk("l3_e1_vld", 32'(l3_vld), 32'd0);
        addr = 32'h4;
        cyc();
        chk("l3_e2_vld", 32'(l3_vld), 32'd0);
        fetch_en = 1'b0;
        cyc();
        chk("l3_e3_vld", 32'(l3_vld), 32'd1);
        chk("l3_e3_rdata", l3_rdata, 32'h00000013);
        fetch_en = 1'b1; addr = 32'h8;
        cyc();
        chk("l3_e4_vld", 32'(l3_vld), 32'd1);
        chk("l3_e4_rdata", l3_rdata, 32'hDEADBEAA);
        fetch_en = 1'b0;
        cyc();
        chk("l3_e5_vld", 32'(l3_vld), 32'd0);
        chk("l3_e5_hold", l3_rdata, 32'hDEADBEAA);
        chk("l3_e5_err", 32'(l3_err), 32'd0);
        cyc();
        chk("l3_e6_vld", 32'(l3_vld), 32'd1);
        chk("l3_e6_rdata", l3_rdata, 32'h00200113);
        chk("l3_e6_err", 32'(l3_err), 32'd0);
        cyc();
        chk("l3_e7_vld", 32'(l3_vld), 32'd0);

        // Reset with two requests in flight
        fetch_en = 1'b1; addr = 32'h0;
        cyc();
        addr = 32'h4;
        cyc();
        fetch_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("l3_rst_vld", 32'(l3_vld), 32'd0);
        cyc(); cyc();
        chk("l3_rst_rdata", l3_rdata, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("l3_no_stale", 32'(l3_vld), 32'd0);
        end
`ifdef INSTR_MEM_PERF_EN
        chk("perf_rst_fcnt", l1_fcnt, 32'd0);
        chk("perf_rst_ecnt", 32'(l3_ecnt), 32'd0);
`endif
        fetch_en = 1'b1; addr = 32'h8;
        cyc();
        fetch_en = 1'b0;
        cyc();
        chk("l3_post_rst_early", 32'(l3_vld), 32'd0);
        cyc();
        chk("l3_post_rst_vld", 32'(l3_vld), 32'd1);
        chk("l3_post_rst_rdata", l3_rdata, 32'h00200113);

`ifdef INSTR_MEM_PERF_EN
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        fetch_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addr = 32'(4 * i);
            cyc();
        end
        addr = 32'h0000_0002;
        cyc();
        addr = 32'h0001_0000;
        cyc();
        fetch_en = 1'b0;
        cyc(); cyc();
        chk("perf_fcnt", l1_fcnt, 32'd12);
        chk("perf_ecnt", 32'(l1_ecnt), 32'd2);
        force u_dut_l1.r_err_cnt = 16'hFFFF;
        #1;
        release u_dut_l1.r_err_cnt;
        fetch_en = 1'b1; addr = 32'h0000_0001;
        cyc();
        fetch_en = 1'b0;
        cyc(); cyc();
        chk("perf_ecnt_sat", 32'(l1_ecnt), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
